// File: rtl/rca_share_pkg.sv
// Shared types, default constants and the round-robin pick helper for the
// rca_share_arbiter slice.
package rca_share_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_e;

  localparam int DEF_W             = 13;
  localparam int DEF_SETTLE_CYCLES = 3;
  localparam int MAX_N             = 8;

  // First asserted bit of req at or after ptr, searching circularly over n
  // requesters. Scanning from the far end lets the closest hit win.
  function automatic logic [2:0] rr_pick(input logic [MAX_N-1:0] req,
                                         input logic [2:0]       ptr,
                                         input int               n);
    logic [2:0] pick;
    int         idx;
    pick = ptr;
    for (int k = MAX_N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && req[idx[2:0]]) pick = idx[2:0];
    end
    return pick;
  endfunction

endpackage

// File: rtl/rca_core.sv
// W-bit full-adder ripple chain; also exposes the carry into the MSB so the
// controller can derive signed overflow.
module rca_core #(
  parameter int W = 13
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         c_msb_o
);

  logic carry;

  // NOTE: every variable assigned in always_comb gets a default before any
  // conditional update; otherwise a path that skips it infers a latch.
  always_comb begin
    carry   = cin_i;
    sum_o   = '0;
    c_msb_o = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) c_msb_o = carry;
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/rca_share_arbiter.sv
// Round-robin controller sharing one ripple-carry add/subtract core between
// N requesters. Optional signed-overflow output: define RCA_SHARE_OVF_EN.
module rca_share_arbiter
  import rca_share_pkg::*;
#(
  parameter int N             = 4,
  parameter int W             = DEF_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int IDW           = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  input  logic [N-1:0]     req_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [W-1:0]     rsp_sum,
  output logic             rsp_cout
`ifdef RCA_SHARE_OVF_EN
  ,
  output logic             rsp_ovf
`endif
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  state_e           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rr_ptr_d;
  logic [IDW-1:0]   id_q;
  logic [W-1:0]     op_a_q;
  logic [W-1:0]     op_b_q;
  logic             cin_q;
  logic [CW-1:0]    cnt_q;
  logic             rsp_valid_q;
  logic [W-1:0]     rsp_sum_q;
  logic             rsp_cout_q;

  logic [MAX_N-1:0] req_pad;
  logic [IDW-1:0]   grant;
  logic             accept;
  logic [W-1:0]     grant_a;
  logic [W-1:0]     grant_b;
  logic             grant_sub;

  logic [W-1:0]     core_sum;
  logic             core_cout;
  logic             core_c_msb;

  always_comb begin
    req_pad          = '0;
    req_pad[N-1:0]   = req_valid;
    grant            = IDW'(rr_pick(req_pad, 3'(rr_ptr_q), N));
    rr_ptr_d         = (int'(grant) == N - 1) ? '0 : grant + IDW'(1);
    accept           = rst_n && (state_q == IDLE) && (|req_valid);
    req_ready        = '0;
    if (accept) req_ready[grant] = 1'b1;
    grant_a          = req_a[int'(grant)*W +: W];
    grant_b          = req_b[int'(grant)*W +: W];
    grant_sub        = req_sub[grant];
  end

  // Operands stay registered for the whole SETTLE window so the ripple chain
  // sees stable inputs until the sum is captured.
  rca_core #(.W(W)) u_core (
    .a_i     (op_a_q),
    .b_i     (op_b_q),
    .cin_i   (cin_q),
    .sum_o   (core_sum),
    .cout_o  (core_cout),
    .c_msb_o (core_c_msb)
  );

`ifdef RCA_SHARE_OVF_EN
  logic rsp_ovf_q;
  assign rsp_ovf = rsp_ovf_q;
`else
  logic unused_core_c_msb;
  assign unused_core_c_msb = core_c_msb;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cin_q       <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
`ifdef RCA_SHARE_OVF_EN
      rsp_ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_a_q   <= grant_a;
            op_b_q   <= grant_sub ? ~grant_b : grant_b;
            cin_q    <= grant_sub;
            id_q     <= grant;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= CW'(SETTLE_CYCLES);
            state_q  <= SETTLE;
          end
        end
        SETTLE: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            rsp_sum_q   <= core_sum;
            rsp_cout_q  <= core_cout;
`ifdef RCA_SHARE_OVF_EN
            rsp_ovf_q   <= core_c_msb ^ core_cout;
`endif
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;

endmodule

// File: doc/rca_share_arbiter.md
Name: rca_share_arbiter

Overview:
- Round-robin controller that shares one W-bit ripple-carry add/subtract datapath between N requesters.
- The datapath is a full-adder chain with multi-gate-delay carry propagation, so the controller holds the registered operands stable for SETTLE_CYCLES clocks before it captures the result.
- It sits between client blocks and the shared adder, and returns the result, carry and requester ID over a valid/ready response port.

Parameters:
- N, 4, number of requesters (2..8)
- W, 13, operand/sum width in bits
- SETTLE_CYCLES, 3, clocks the operands are held before the sum is captured (>=1)
- IDW, $clog2(N), requester ID width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N  per-requester request valid
- req_ready  out  N  per-requester accept; one-hot or zero
- req_a  in  N*W  packed operand A; slice i = bits [i*W +: W]
- req_b  in  N*W  packed operand B
- req_sub  in  N  1 = A-B, 0 = A+B
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_id  out  IDW  index of the served requester
- rsp_sum  out  W  sum/difference, two's complement modulo 2^W
- rsp_cout  out  1  carry out of the MSB; for subtract, 1 = no borrow
- rsp_ovf  out  1  signed overflow (present only with the optional feature)

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, rr_ptr=0.
  - Operand registers cleared.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0.
  - req_ready=0 while rst_n=0.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - grant = first asserted req_valid at or after rr_ptr, searching circularly.
  - req_ready[grant]=1, and only in IDLE (combinational from req_valid and rr_ptr).
  - On the handshake edge:
    - op_a <= A[g].
    - op_b <= sub ? ~B[g] : B[g].
    - cin <= sub.
    - id <= g.
    - rr_ptr <= (g+1) mod N.
    - cnt <= SETTLE_CYCLES.
    - state -> SETTLE.
  - No request: remain in IDLE, rr_ptr unchanged.
- SETTLE:
  - op_a, op_b and cin drive the shared adder and are held constant.
  - cnt decrements every edge.
  - On the edge where cnt==1: capture the adder sum/cout (and ovf) into rsp_*; state -> RESP.
- Latency: rsp_valid rises SETTLE_CYCLES edges after the accept edge (default 3).
- RESP:
  - rsp_valid=1; all rsp_* held stable until the rsp_valid&rsp_ready edge.
  - Then state -> IDLE; rsp_valid <= 0. The next accept is possible one cycle later; there is no back-to-back overlap.
- Arithmetic: sum = (A + (sub?~B:B) + sub) mod 2^W, with cout = carry out of bit W-1.
- Backpressure: req_ready=0 for all requesters whenever state!=IDLE; a requester holds valid and data until accepted.
- Mid-operation deassertion:
  - A requester that drops valid before grant is simply skipped.
  - Dropping valid after acceptance has no effect.
- Reset mid-SETTLE or mid-RESP: the operation is discarded, all outputs return to reset values, and no response is emitted.
- Fairness: a continuously requesting requester waits at most N-1 other services.

Optional Feature:
- Macro: RCA_SHARE_OVF_EN.
- Defined:
  - The rsp_ovf port exists.
  - rsp_ovf = carry into MSB XOR carry out of MSB, captured with rsp_sum.
- Undefined:
  - The rsp_ovf port and its register are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package rca_share_pkg:
  - state enum {IDLE, SETTLE, RESP}.
  - Default constants for W and SETTLE_CYCLES.
  - Function rr_pick(req, ptr) returning the grant index.
- Sub-module rca_core (W-bit full-adder ripple chain with cin, sum, cout, and the MSB carry-in for overflow) instantiated once; the controller contains only the FSM, arbiter and registers.

Test Plan:
- Add, N=4, W=13: req0 A=-10 (0x1FF6), B=100, sub=0 → rsp_id=0, rsp_sum=0x005A (90), rsp_cout=1; rsp_valid rises exactly 3 edges after accept.
- Subtract: req2 A=1000, B=2001, sub=1 → rsp_sum=0x1C17 (-1001), rsp_cout=0; with RCA_SHARE_OVF_EN, rsp_ovf=0.
- Overflow (RCA_SHARE_OVF_EN): A=4095, B=1, sub=0 → rsp_sum=0x1000, rsp_cout=0, rsp_ovf=1.
- Round-robin: all four req_valid held high from reset, rsp_ready=1 → rsp_id sequence 0,1,2,3,0; req_ready never has more than one bit set.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_* stable, req_ready=0; release → one handshake, then IDLE.
- Reset in SETTLE: assert rst_n=0 when cnt=2 → rsp_valid=0 immediately, no response after release, and the next grant starts at rr_ptr=0.
